// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: issues read strobes, absorbs the one-cycle
// read latency in a 3-entry skid buffer, and frames a valid/ready stream into packets.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int PKT_LEN   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_rd_error_i,
    output logic                 fifo_rd_en_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o,
    output logic [CNT_WIDTH-1:0] word_cnt_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o,
    output logic                 rd_error_o
);

    // state | meaning
    // E0    | skid buffer empty
    // E1    | one beat buffered (head valid)
    // E2    | two beats buffered
    // E3    | three beats buffered (full)
    typedef enum logic [1:0] {E0 = 2'd0, E1 = 2'd1, E2 = 2'd2, E3 = 2'd3} occ_t;

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);

    occ_t             occ;
    logic             inflight;
    logic [WIDTH-1:0] skid [3];
    logic [BW-1:0]    beat_idx;
    logic             pop;
    logic             cap;
    logic [1:0]       occ_v;
    logic [1:0]       occ_n;
    logic [1:0]       wr_idx;

    assign m_valid_o = (occ != E0);
    assign m_data_o  = skid[0];
    assign m_last_o  = m_valid_o & (beat_idx == LAST_IDX);
    assign pop       = m_valid_o & m_ready_i;
    assign cap       = inflight;
    assign occ_v     = occ;

    // Buffered plus in-flight beats must stay below three so every issued read has a slot.
    assign fifo_rd_en_o = !clr_i && !fifo_empty_i &&
                          (({1'b0, occ_v} + {2'b00, inflight}) < 3'd3);

    always_comb begin
        occ_n  = occ_v;
        wr_idx = occ_v;
        if (cap && !pop)
            occ_n = occ_v + 2'd1;
        else if (!cap && pop)
            occ_n = occ_v - 2'd1;
        if (pop)
            wr_idx = occ_v - 2'd1;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            occ        <= E0;
            inflight   <= 1'b0;
            beat_idx   <= '0;
            word_cnt_o <= '0;
            pkt_cnt_o  <= '0;
            rd_error_o <= 1'b0;
            skid[0]    <= '0;
            skid[1]    <= '0;
            skid[2]    <= '0;
        end else begin
            occ      <= occ_t'(occ_n);
            inflight <= fifo_rd_en_o;
            if (pop) begin
                skid[0]    <= skid[1];
                skid[1]    <= skid[2];
                word_cnt_o <= word_cnt_o + CNT_WIDTH'(1);
                if (m_last_o) begin
                    pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
                    beat_idx  <= '0;
                end else begin
                    beat_idx  <= beat_idx + BW'(1);
                end
            end
            // Tail write follows the shift so a simultaneous pop and capture keeps order.
            if (cap) begin
                case (wr_idx)
                    2'd0:    skid[0] <= fifo_rdata_i;
                    2'd1:    skid[1] <= fifo_rdata_i;
                    2'd2:    skid[2] <= fifo_rdata_i;
                    default: ;
                endcase
            end
            if (fifo_rd_error_i || (fifo_rd_en_o && fifo_empty_i))
                rd_error_o <= 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (clr_i)
                                    !(cap && !pop && occ == E3));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, stream scoreboard and framing/counter model.
module tb_fifo_rd_stream;

    localparam int WIDTH     = 8;
    localparam int PKT_LEN   = 4;
    localparam int CNT_WIDTH = 4;

    logic                 clk_i;
    logic                 clr_i;
    logic                 fifo_empty_i;
    logic [WIDTH-1:0]     fifo_rdata_i;
    logic                 fifo_rd_error_i;
    logic                 fifo_rd_en_o;
    logic [WIDTH-1:0]     m_data_o;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic                 m_last_o;
    logic [CNT_WIDTH-1:0] word_cnt_o;
    logic [CNT_WIDTH-1:0] pkt_cnt_o;
    logic                 rd_error_o;

    fifo_rd_stream #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i           (clk_i),
        .clr_i           (clr_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_rdata_i    (fifo_rdata_i),
        .fifo_rd_error_i (fifo_rd_error_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_ready_i       (m_ready_i),
        .m_last_o        (m_last_o),
        .word_cnt_o      (word_cnt_o),
        .pkt_cnt_o       (pkt_cnt_o),
        .rd_error_o      (rd_error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        int             nwords;
        logic [7:0]     base;
        logic [3:0]     pat;
        int             cycles;
        logic [3:0]     exp_word;
        logic [3:0]     exp_pkt;
    } vec_t;

    vec_t vecs [4];

    logic [WIDTH-1:0]     fifo_q [$];
    logic [WIDTH-1:0]     exp_q  [$];
    logic [CNT_WIDTH-1:0] mdl_word;
    logic [CNT_WIDTH-1:0] mdl_pkt;
    logic                 mdl_err;
    int                   mdl_beat;
    int                   compared;
    int                   mismatched;
    int                   hs_total;
    int                   rd_cnt;
    int                   cyc;
    int                   first_hs;
    int                   last_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        fifo_empty_i = 1'b0;
    endtask

    // Samples the stream at the falling edge; updates the FIFO model just after the rising edge.
    task automatic monitor();
        logic       rd_pending;
        logic [7:0] e;
        logic       exp_last;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (clr_i) begin
                chk("rd_en_during_clr", {31'd0, fifo_rd_en_o}, 32'd0);
                exp_q    = fifo_q;
                mdl_word = '0;
                mdl_pkt  = '0;
                mdl_beat = 0;
                mdl_err  = 1'b0;
            end else begin
                chk("word_cnt", {28'd0, word_cnt_o}, {28'd0, mdl_word});
                chk("pkt_cnt", {28'd0, pkt_cnt_o}, {28'd0, mdl_pkt});
                chk("rd_error", {31'd0, rd_error_o}, {31'd0, mdl_err});
                if (!m_valid_o)
                    chk("last_without_valid", {31'd0, m_last_o}, 32'd0);
                if (m_valid_o && m_ready_i) begin
                    exp_last = (mdl_beat == PKT_LEN - 1);
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", {24'd0, m_data_o}, {24'd0, e});
                        chk("beat_last", {31'd0, m_last_o}, {31'd0, exp_last});
                    end
                    mdl_word = mdl_word + 4'd1;
                    if (exp_last) begin
                        mdl_pkt  = mdl_pkt + 4'd1;
                        mdl_beat = 0;
                    end else begin
                        mdl_beat++;
                    end
                    hs_total++;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
                if (fifo_rd_error_i) mdl_err = 1'b1;
            end
            rd_pending = fifo_rd_en_o;
            @(posedge clk_i);
            #1;
            if (rd_pending) begin
                rd_cnt++;
                if (fifo_q.size() > 0) fifo_rdata_i = fifo_q.pop_front();
            end else begin
                fifo_rdata_i = 8'hEE;
            end
            fifo_empty_i = (fifo_q.size() == 0);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid_o) && n < budget) begin
            step(1);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        int start;
        int n;
        int rd0;
        clr_i           = 1'b1;
        m_ready_i       = 1'b0;
        fifo_rd_error_i = 1'b0;
        fifo_empty_i    = 1'b1;
        fifo_rdata_i    = '0;
        compared = 0; mismatched = 0; hs_total = 0; rd_cnt = 0; cyc = 0;
        first_hs = -1; last_hs = -1;
        mdl_word = '0; mdl_pkt = '0; mdl_err = 1'b0; mdl_beat = 0;

        // cumulative counts after each row, modulo 16 (CNT_WIDTH=4), PKT_LEN=4
        vecs[0] = '{nwords: 8, base: 8'h10, pat: 4'b1111, cycles: 20, exp_word: 4'd8,  exp_pkt: 4'd2};
        vecs[1] = '{nwords: 6, base: 8'h20, pat: 4'b0101, cycles: 30, exp_word: 4'd14, exp_pkt: 4'd3};
        vecs[2] = '{nwords: 5, base: 8'h30, pat: 4'b0011, cycles: 30, exp_word: 4'd3,  exp_pkt: 4'd4};
        vecs[3] = '{nwords: 9, base: 8'h40, pat: 4'b0111, cycles: 40, exp_word: 4'd12, exp_pkt: 4'd7};

        fork
            monitor();
        join_none

        // Reset with a non-empty FIFO
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        step(2);
        chk("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
        chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_last", {31'd0, m_last_o}, 32'd0);
        chk("rst_data", {24'd0, m_data_o}, 32'd0);
        chk("rst_word_cnt", {28'd0, word_cnt_o}, 32'd0);
        chk("rst_pkt_cnt", {28'd0, pkt_cnt_o}, 32'd0);
        chk("rst_rd_error", {31'd0, rd_error_o}, 32'd0);
        clr_i     = 1'b0;
        m_ready_i = 1'b1;
        drain(100);
        pulse_clr();

        // Streaming and ready patterns
        for (int r = 0; r < 4; r++) begin
            m_ready_i = 1'b0;
            for (int k = 0; k < vecs[r].nwords; k++) push(vecs[r].base + 8'(k));
            first_hs = -1;
            for (int c = 0; c < vecs[r].cycles; c++) begin
                m_ready_i = vecs[r].pat[c % 4];
                step(1);
            end
            m_ready_i = 1'b1;
            drain(100);
            chk("row_word_cnt", {28'd0, word_cnt_o}, {28'd0, vecs[r].exp_word});
            chk("row_pkt_cnt", {28'd0, pkt_cnt_o}, {28'd0, vecs[r].exp_pkt});
            if (vecs[r].pat == 4'b1111)
                chk("throughput_span", last_hs - first_hs, vecs[r].nwords - 1);
        end

        // Backpressure: exactly three reads, head held
        m_ready_i = 1'b0;
        rd0 = rd_cnt;
        for (int k = 0; k < 12; k++) push(8'h50 + 8'(k));
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (c >= 4) begin
                chk("bp_valid", {31'd0, m_valid_o}, 32'd1);
                chk("bp_hold_data", {24'd0, m_data_o}, 32'h50);
                chk("bp_hold_last", {31'd0, m_last_o}, 32'd0);
            end
        end
        chk("bp_reads", rd_cnt - rd0, 32'd3);
        m_ready_i = 1'b1;
        drain(100);

        // Reset after two beats of a packet
        pulse_clr();
        start = hs_total;
        for (int k = 0; k < 10; k++) push(8'h60 + 8'(k));
        n = 0;
        while (hs_total < start + 2 && n < 50) begin
            step(1);
            n++;
        end
        chk("midpkt_beats", hs_total - start, 32'd2);
        pulse_clr();
        chk("midpkt_word_cnt", {28'd0, word_cnt_o}, 32'd0);
        chk("midpkt_pkt_cnt", {28'd0, pkt_cnt_o}, 32'd0);
        chk("midpkt_valid", {31'd0, m_valid_o}, 32'd0);
        drain(100);

        // Counter wrap and sticky error
        pulse_clr();
        for (int k = 0; k < 16; k++) push(8'h70 + 8'(k));
        drain(100);
        chk("wrap_word_cnt", {28'd0, word_cnt_o}, 32'd0);
        chk("wrap_pkt_cnt", {28'd0, pkt_cnt_o}, 32'd4);
        fifo_rd_error_i = 1'b1;
        step(1);
        fifo_rd_error_i = 1'b0;
        step(5);
        chk("err_sticky", {31'd0, rd_error_o}, 32'd1);
        push(8'h81);
        push(8'h82);
        drain(100);
        chk("err_after_stream", {31'd0, rd_error_o}, 32'd1);
        pulse_clr();
        chk("err_cleared", {31'd0, rd_error_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
